keypad_scan_encoder: RTL and testbench
======================================

Name: keypad_scan_encoder

Overview:
- Initiator side of the 4x4 matrix-keypad interface. Drives the active-low column strobes `shift_col`, samples the active-low `row` lines and debounces across full scans.
- Delivers one decoded 4-bit `key_value` plus a single-cycle `key_valid` per physical press to the vending-machine controller.
- Replaces externally driven column strobes: the controller then needs only `key_value`/`key_valid`.

Parameters:
- SCAN_DIV, 1000, clock cycles each column stays active (dwell); must be >= 3.
- DEBOUNCE_SCANS, 4, consecutive full scans needed to accept a press and, separately, to accept a release; >= 1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- row  input  4  keypad rows, active-low, asynchronous to clk
- shift_col  output  4  column strobe, active-low one-hot
- key_value  output  4  code of last accepted key
- key_valid  output  1  one-cycle pulse when a press is accepted
- key_held  output  1  high from acceptance until release accepted

Behaviour:
- Reset (clk edge with reset=1):
  - shift_col=4'b1110; dwell counter=0; column index=0.
  - row synchronizer=4'hF; FSM=IDLE; debounce/release counters=0.
  - key_value=0, key_valid=0, key_held=0.
- Synchronizer: `row` passes through a 2-flop synchronizer; all sampling uses the synchronized value.
- Scanning:
  - Column c is active (shift_col[c]=0, others 1) for SCAN_DIV cycles.
  - The synchronized row is sampled on the last dwell cycle (dwell==SCAN_DIV-1).
  - The column advances on the next cycle, wrapping 3->0.
  - A full scan is 4*SCAN_DIV cycles; scanning never stops.
- Scan result: accumulated over columns 0..3 and evaluated at the column-3 sample.
  - NONE: no active row bit in any column.
  - KEY(code): exactly one active bit in the whole scan.
  - MULTI: two or more active bits.
- Key map (row r, col c), c=0..3:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- FSM, evaluated once per full scan:
  - IDLE:
    - KEY(k) -> DEBOUNCE, candidate=k, cnt=1.
    - If DEBOUNCE_SCANS==1, accept immediately instead.
  - DEBOUNCE:
    - KEY(candidate) -> cnt+1; when cnt reaches DEBOUNCE_SCANS, accept.
    - KEY(other) -> restart with new candidate, cnt=1.
    - NONE or MULTI -> IDLE, cnt=0.
  - Accept:
    - key_value<=candidate.
    - key_valid=1 for exactly the cycle after the column-3 sample edge.
    - key_held<=1; FSM -> PRESSED.
  - PRESSED:
    - NONE -> rel=1 and enter RELEASE (if DEBOUNCE_SCANS==1, release immediately).
    - KEY(any) or MULTI -> stay, no new pulse, key_value unchanged.
  - RELEASE:
    - NONE -> rel+1; at DEBOUNCE_SCANS -> IDLE, key_held<=0.
    - KEY or MULTI -> PRESSED, rel=0.
- Output rules:
  - key_value holds its last accepted code indefinitely; it is not cleared on release.
  - key_valid never asserts twice for one press.
  - Minimum press latency is DEBOUNCE_SCANS full scans after the first scan that sees the key.
- Reset mid-operation: reset has priority over every event. It aborts debounce/release, and a held key must then be re-debounced from IDLE; it is reported again once accepted.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2; full scan = 16 cycles):
1. Reset, no keys -> `shift_col` is 1110 for 4 cycles, then 1101, 1011, 0111, then 1110 again; `key_valid` stays 0 and `key_value` stays 0.
2. Hold row1 low whenever col1 is active (key 5) -> `key_valid` is a single 1-cycle pulse after the 2nd full scan, with `key_value`=5 and `key_held`=1; holding it 10 more scans gives no further pulses.
3. Key 9 (row2/col2) present for 1 scan, then absent -> no pulse, `key_value` stays at its previous value, FSM returns to IDLE.
4. After test 2, release for 1 scan, then re-press 5 -> no pulse and `key_held` stays 1. Release for 2 scans -> `key_held`=0. Press again -> a new pulse after 2 scans.
5. Press 1 (r0c0) and F (r3c2) together -> MULTI, no pulse. Press 2 until accepted (`key_value`=2), then add 3 -> no pulse and `key_value` stays 2 until both are released for 2 scans.
6. Assert reset for 1 cycle midway through debouncing key 0 (r3c1, held throughout) -> all outputs return to reset values; the pulse for 0 arrives only 2 full scans after the restarted scan.

Source files
------------

// File: rtl/keypad_scan_encoder.sv
// rtl/keypad_scan_encoder.sv - 4x4 keypad column scanner with per-scan debounce and key encoding
module keypad_scan_encoder #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] shift_col,
    output logic [3:0] key_value,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DONE   = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    logic [3:0]    row_s1, row_s2;
    logic [DW-1:0] dwell;
    logic [1:0]    col;
    logic          sample, scan_done;

    logic [3:0] hits;
    logic [2:0] hit_cnt;
    logic [1:0] hit_row;
    logic [1:0] col_cnt;
    logic [1:0] acc_cnt, tot_cnt;
    logic [3:0] acc_code, tot_code;
    logic [2:0] sum_cnt;

    state_t        state, state_n;
    logic [3:0]    cand, cand_n;
    logic [CW-1:0] cnt, cnt_n, rel, rel_n;
    logic [3:0]    value_n;
    logic          valid_n, held_n, accept;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
            4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
            4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
            4'hC: key_map = 4'hE;  4'hD: key_map = 4'h0;  4'hE: key_map = 4'hF;  default: key_map = 4'hD;
        endcase
    endfunction

    assign sample    = (dwell == DWELL_LAST);
    assign scan_done = sample && (col == 2'd3);
    assign shift_col = ~(4'b0001 << col);
    assign hits      = ~row_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            row_s1 <= 4'hF;
            row_s2 <= 4'hF;
            dwell  <= '0;
            col    <= 2'd0;
        end else begin
            row_s1 <= row;
            row_s2 <= row_s1;
            if (sample) begin
                dwell <= '0;
                col   <= col + 2'd1;
            end else begin
                dwell <= dwell + DW'(1);
            end
        end
    end

    // Per-scan tally saturates at 2: anything beyond one active contact is MULTI.
    always_comb begin
        hit_cnt = 3'(hits[0]) + 3'(hits[1]) + 3'(hits[2]) + 3'(hits[3]);
        hit_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (hits[i]) hit_row = 2'(i);
        end
        col_cnt  = (hit_cnt >= 3'd2) ? 2'd2 : hit_cnt[1:0];
        sum_cnt  = {1'b0, acc_cnt} + {1'b0, col_cnt};
        tot_cnt  = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
        tot_code = (col_cnt == 2'd1) ? key_map(hit_row, col) : acc_code;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_cnt  <= 2'd0;
            acc_code <= 4'h0;
        end else if (scan_done) begin
            acc_cnt  <= 2'd0;
            acc_code <= 4'h0;
        end else if (sample) begin
            acc_cnt  <= tot_cnt;
            acc_code <= tot_code;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cand      <= 4'h0;
            cnt       <= '0;
            rel       <= '0;
            key_value <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_n;
            cand      <= cand_n;
            cnt       <= cnt_n;
            rel       <= rel_n;
            key_value <= value_n;
            key_valid <= valid_n;
            key_held  <= held_n;
        end
    end

    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        rel_n   = rel;
        value_n = key_value;
        valid_n = 1'b0;
        held_n  = key_held;
        accept  = 1'b0;
        if (scan_done) begin
            case (state)
                IDLE: begin
                    if (tot_cnt == 2'd1) begin
                        cand_n = tot_code;
                        if (DEBOUNCE_SCANS == 1) begin
                            accept = 1'b1;
                        end else begin
                            state_n = DEBOUNCE;
                            cnt_n   = CNT_ONE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (tot_cnt == 2'd1 && tot_code == cand) begin
                        if (cnt + CNT_ONE == CNT_DONE) accept = 1'b1;
                        else cnt_n = cnt + CNT_ONE;
                    end else if (tot_cnt == 2'd1) begin
                        cand_n = tot_code;
                        cnt_n  = CNT_ONE;
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
                PRESSED: begin
                    if (tot_cnt == 2'd0) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            state_n = IDLE;
                            held_n  = 1'b0;
                        end else begin
                            state_n = RELEASE;
                            rel_n   = CNT_ONE;
                        end
                    end
                end
                default: begin
                    if (tot_cnt != 2'd0) begin
                        state_n = PRESSED;
                        rel_n   = '0;
                    end else if (rel + CNT_ONE == CNT_DONE) begin
                        state_n = IDLE;
                        held_n  = 1'b0;
                        rel_n   = '0;
                    end else begin
                        rel_n = rel + CNT_ONE;
                    end
                end
            endcase
            if (accept) begin
                state_n = PRESSED;
                cnt_n   = '0;
                value_n = tot_code;
                valid_n = 1'b1;
                held_n  = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// tb/tb_keypad_scan_encoder.sv - vector table, reset corner cases and random scans against a scan-level model
module tb_keypad_scan_encoder;

    localparam int SD = 4;
    localparam int DS = 2;
    localparam int SCAN = 4 * SD;

    localparam logic [15:0] K0 = 16'h2000, K1 = 16'h0001, K2 = 16'h0002, K3 = 16'h0004;
    localparam logic [15:0] K5 = 16'h0020, K9 = 16'h0400, KF = 16'h4000;
    localparam logic [3:0] KEYMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                           4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row, shift_col, key_value;
    logic        key_valid, key_held;
    logic [15:0] pressed = 16'h0;

    int checks = 0;
    int failures = 0;

    keypad_scan_encoder #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
        .clk(clk), .reset(reset), .row(row), .shift_col(shift_col),
        .key_value(key_value), .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clk = ~clk;

    // Passive keypad: a row is pulled low when a pressed key sits on the active column.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !shift_col[c]) row[r] = 1'b0;
    end

    typedef struct {
        logic [15:0] mask;
        int          reps;
        logic        valid;
        logic [3:0]  value;
        logic        held;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_shift_col", 32'(shift_col), 32'hE);
        check("reset_key_value", 32'(key_value), 32'h0);
        check("reset_key_valid", 32'(key_valid), 32'h0);
        check("reset_key_held", 32'(key_held), 32'h0);
        reset = 1'b0;
    endtask

    // One full scan starting at column 0; the accept pulse belongs to the last edge.
    task automatic run_scan(input logic [15:0] mask, input logic ev, input logic [3:0] eval,
                            input logic eh, input string tag);
        int early;
        logic [3:0] exp_col;
        early = 0;
        pressed = mask;
        for (int i = 1; i <= SCAN; i++) begin
            @(posedge clk);
            #1;
            exp_col = ~(4'b0001 << ((i / SD) % 4));
            check({tag, "_shift_col"}, 32'(shift_col), 32'(exp_col));
            if (i < SCAN && key_valid) early++;
        end
        check({tag, "_early_pulse"}, 32'(early), 32'h0);
        check({tag, "_key_valid"}, 32'(key_valid), 32'(ev));
        check({tag, "_key_value"}, 32'(key_value), 32'(eval));
        check({tag, "_key_held"}, 32'(key_held), 32'(eh));
    endtask

    bit         m_held;
    int         m_streak, m_none;
    logic [3:0] m_cand, m_value;

    task automatic model_reset();
        m_held = 0; m_streak = 0; m_none = 0; m_cand = 4'h0; m_value = 4'h0;
    endtask

    // Scan-level behaviour: DS identical single-key scans accept, DS empty scans release.
    task automatic model_step(input logic [15:0] mask, output logic ev, output logic [3:0] eval,
                              output logic eh);
        int n;
        logic [3:0] code;
        n = $countones(mask);
        code = 4'h0;
        for (int b = 0; b < 16; b++) if (mask[b]) code = KEYMAP[b];
        ev = 1'b0;
        if (!m_held) begin
            if (n == 1) begin
                if (m_streak > 0 && code == m_cand) m_streak++;
                else begin
                    m_cand = code;
                    m_streak = 1;
                end
                if (m_streak >= DS) begin
                    ev = 1'b1; m_value = code; m_held = 1; m_streak = 0; m_none = 0;
                end
            end else begin
                m_streak = 0;
            end
        end else if (n == 0) begin
            m_none++;
            if (m_none >= DS) begin
                m_held = 0; m_none = 0;
            end
        end else begin
            m_none = 0;
        end
        eval = m_value;
        eh = m_held;
    endtask

    vec_t vecs[$];

    initial begin
        logic        ev, eh;
        logic [3:0]  eval;
        logic [15:0] mask, last_single;
        int          r, a, b;

        vecs = '{
            '{16'h0,   2, 1'b0, 4'h0, 1'b0},
            '{K5,      1, 1'b0, 4'h0, 1'b0},
            '{K5,      1, 1'b1, 4'h5, 1'b1},
            '{K5,     10, 1'b0, 4'h5, 1'b1},
            '{16'h0,   1, 1'b0, 4'h5, 1'b1},
            '{K5,      1, 1'b0, 4'h5, 1'b1},
            '{16'h0,   1, 1'b0, 4'h5, 1'b1},
            '{16'h0,   1, 1'b0, 4'h5, 1'b0},
            '{K5,      1, 1'b0, 4'h5, 1'b0},
            '{K5,      1, 1'b1, 4'h5, 1'b1},
            '{16'h0,   1, 1'b0, 4'h5, 1'b1},
            '{16'h0,   1, 1'b0, 4'h5, 1'b0},
            '{K9,      1, 1'b0, 4'h5, 1'b0},
            '{16'h0,   1, 1'b0, 4'h5, 1'b0},
            '{K9,      1, 1'b0, 4'h5, 1'b0},
            '{K9,      1, 1'b1, 4'h9, 1'b1},
            '{16'h0,   1, 1'b0, 4'h9, 1'b1},
            '{16'h0,   1, 1'b0, 4'h9, 1'b0},
            '{K9,      1, 1'b0, 4'h9, 1'b0},
            '{K5,      1, 1'b0, 4'h9, 1'b0},
            '{K5,      1, 1'b1, 4'h5, 1'b1},
            '{16'h0,   1, 1'b0, 4'h5, 1'b1},
            '{16'h0,   1, 1'b0, 4'h5, 1'b0},
            '{K1 | KF, 2, 1'b0, 4'h5, 1'b0},
            '{K2,      1, 1'b0, 4'h5, 1'b0},
            '{K2,      1, 1'b1, 4'h2, 1'b1},
            '{K2 | K3, 3, 1'b0, 4'h2, 1'b1},
            '{16'h0,   1, 1'b0, 4'h2, 1'b1},
            '{16'h0,   1, 1'b0, 4'h2, 1'b0}
        };

        do_reset();
        for (int v = 0; v < vecs.size(); v++)
            for (int k = 0; k < vecs[v].reps; k++)
                run_scan(vecs[v].mask, vecs[v].valid, vecs[v].value, vecs[v].held,
                         $sformatf("vec%0d_%0d", v, k));

        // Reset mid-debounce of key 0: debounce restarts from the next full scan.
        run_scan(K0, 1'b0, 4'h2, 1'b0, "k0_first");
        repeat (7) @(posedge clk);
        #1;
        do_reset();
        run_scan(K0, 1'b0, 4'h0, 1'b0, "k0_restart1");
        run_scan(K0, 1'b1, 4'h0, 1'b1, "k0_restart2");
        // Reset while the key is held: it must be reported again.
        repeat (5) @(posedge clk);
        #1;
        do_reset();
        run_scan(K0, 1'b0, 4'h0, 1'b0, "k0_reheld1");
        run_scan(K0, 1'b1, 4'h0, 1'b1, "k0_reheld2");
        run_scan(K9, 1'b0, 4'h0, 1'b1, "k9_while_held");

        do_reset();
        model_reset();
        last_single = K5;
        for (int s = 0; s < 150; s++) begin
            r = $urandom_range(0, 9);
            if (r < 3) begin
                mask = 16'h0;
            end else if (r < 8) begin
                if ($urandom_range(0, 3) == 0) last_single = 16'(1) << $urandom_range(0, 15);
                mask = last_single;
            end else begin
                a = $urandom_range(0, 15);
                b = (a + 1 + $urandom_range(0, 14)) % 16;
                mask = (16'(1) << a) | (16'(1) << b);
            end
            model_step(mask, ev, eval, eh);
            run_scan(mask, ev, eval, eh, $sformatf("rand%0d", s));
        end
        pressed = 16'h0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
